// File: rtl/text_pkg.sv
// Shared definitions for the text-mode character buffer writer: control codes,
// FSM and cursor-operation encodings, and default grid geometry.
package text_pkg;

  localparam int DEF_COLS   = 80;
  localparam int DEF_ROWS   = 40;
  localparam int DEF_ADDR_W = 13;

  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] FF = 8'h0C;
  localparam logic [7:0] CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCROLL_RD,
    SCROLL_WR
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADV,
    OP_NL,
    OP_CR,
    OP_BS,
    OP_HOME
  } cur_op_t;

endpackage

// File: rtl/text_cursor.sv
// Cursor column/row registers with advance, newline, CR, backspace and home.
// TEXT_WRITER_SCROLL_EN: row overflow keeps the last row instead of wrapping to 0.
module text_cursor
  import text_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  cur_op_t    op,
  output logic [6:0] col,
  output logic [5:0] row,
  output logic       overflow
);

  logic [6:0] col_d;
  logic [5:0] row_d;
  logic       last_col;
  logic       last_row;
  logic       row_step;

  assign last_col = (col == 7'(COLS - 1));
  assign last_row = (row == 6'(ROWS - 1));
  assign row_step = (op == OP_NL) || ((op == OP_ADV) && last_col);
  assign overflow = row_step && last_row;

  always_comb begin
    col_d = col;
    row_d = row;
    case (op)
      OP_ADV:       col_d = last_col ? 7'd0 : col + 7'd1;
      OP_NL, OP_CR: col_d = 7'd0;
      OP_BS:        if (col != 7'd0) col_d = col - 7'd1;
      OP_HOME: begin
        col_d = 7'd0;
        row_d = 6'd0;
      end
      default: ;
    endcase
    if (row_step) begin
`ifdef TEXT_WRITER_SCROLL_EN
      if (!last_row) row_d = row + 6'd1;
`else
      row_d = last_row ? 6'd0 : row + 6'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= 7'd0;
      row <= 6'd0;
    end else begin
      col <= col_d;
      row <= row_d;
    end
  end

endmodule

// File: rtl/text_writer.sv
// Character-stream writer for the VGA text buffer: byte handshake in, cell writes out.
// TEXT_WRITER_SCROLL_EN: row overflow scrolls the screen up instead of wrapping.
module text_writer
  import text_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              buf_we,
  output logic              buf_re,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  input  logic [7:0]        buf_rdata,
  output logic [6:0]        cur_col,
  output logic [5:0]        cur_row,
  output logic              busy
);

  // Handshake: a byte transfers on a rising edge with in_valid && in_ready;
  // in_ready is high only in IDLE and in_data must be held while it is low.

  localparam logic [ADDR_W-1:0] CELLS   = ADDR_W'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] ROW_LEN = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [ADDR_W-1:0] addr_d, cur_addr, clr_end;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_d;
  logic              clr_row0, clr_row0_d;
  logic              accept;
  logic              overflow;
  cur_op_t           op;

  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;
  assign accept   = in_valid && in_ready;
  assign cur_addr = ADDR_W'(cur_row) * ROW_LEN + ADDR_W'(cur_col);
  assign clr_end  = clr_row0 ? ROW_LEN : CELLS;

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk      (clk_25),
    .rst_n    (rst_n),
    .op       (op),
    .col      (cur_col),
    .row      (cur_row),
    .overflow (overflow)
  );

  always_comb begin
    op = OP_NONE;
    if (accept) begin
      case (in_data)
        CR:      op = OP_CR;
        LF:      op = OP_NL;
        BS:      op = OP_BS;
        FF:      op = OP_HOME;
        default: op = OP_ADV;
      endcase
    end
  end

`ifdef TEXT_WRITER_SCROLL_EN
  localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'((ROWS - 1) * COLS - 1);
  logic re_d, from_rd, from_rd_d;
  // Copied bytes go straight from the read port to the write port.
  assign buf_wdata = from_rd ? buf_rdata : wdata_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^buf_rdata;
  assign buf_re       = 1'b0;
  assign buf_wdata    = wdata_q;
`endif

  // Strobes are registered: each state names the access launched at its outgoing edge.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    we_d       = 1'b0;
    addr_d     = buf_addr;
    wdata_d    = wdata_q;
    clr_row0_d = clr_row0;
`ifdef TEXT_WRITER_SCROLL_EN
    re_d      = 1'b0;
    from_rd_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (op == OP_HOME) begin
          state_d    = CLEAR;
          clr_row0_d = 1'b0;
          we_d       = 1'b1;
          addr_d     = '0;
          wdata_d    = 8'h00;
          cnt_d      = ONE;
        end else if (op == OP_ADV) begin
          we_d    = 1'b1;
          addr_d  = cur_addr;
          wdata_d = in_data;
        end
        // A glyph already owns the next cycle's port, so its overflow starts one cycle later.
        if (overflow) begin
          cnt_d = '0;
`ifdef TEXT_WRITER_SCROLL_EN
          clr_row0_d = 1'b0;
          if (op == OP_NL) begin
            state_d = SCROLL_WR;
            re_d    = 1'b1;
            addr_d  = ROW_LEN;
          end else begin
            state_d = SCROLL_RD;
          end
`else
          state_d    = CLEAR;
          clr_row0_d = 1'b1;
          if (op == OP_NL) begin
            we_d    = 1'b1;
            addr_d  = '0;
            wdata_d = 8'h00;
            cnt_d   = ONE;
          end
`endif
        end
      end
      CLEAR: begin
        if (cnt == clr_end) begin
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          addr_d  = cnt;
          wdata_d = 8'h00;
          cnt_d   = cnt + ONE;
        end
      end
`ifdef TEXT_WRITER_SCROLL_EN
      SCROLL_RD: begin
        re_d    = 1'b1;
        addr_d  = cnt + ROW_LEN;
        state_d = SCROLL_WR;
      end
      SCROLL_WR: begin
        we_d      = 1'b1;
        addr_d    = cnt;
        wdata_d   = 8'h00;
        from_rd_d = 1'b1;
        cnt_d     = cnt + ONE;
        state_d   = (cnt == COPY_LAST) ? CLEAR : SCROLL_RD;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      buf_we   <= 1'b0;
      buf_addr <= '0;
      wdata_q  <= 8'h00;
      clr_row0 <= 1'b0;
`ifdef TEXT_WRITER_SCROLL_EN
      buf_re  <= 1'b0;
      from_rd <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      buf_we   <= we_d;
      buf_addr <= addr_d;
      wdata_q  <= wdata_d;
      clr_row0 <= clr_row0_d;
`ifdef TEXT_WRITER_SCROLL_EN
      buf_re  <= re_d;
      from_rd <= from_rd_d;
`endif
    end
  end

endmodule
